// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders and an OR for the carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell per cycle, LSB first, IDLE/RUN/DONE control.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_RAW = $clog2(WIDTH + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status next values; the result register only updates on the final bit
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sr_d    = (sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d  = sr_d;
          cout_d = fa_c;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl against an arithmetic reference.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic         s1_start;
  logic [0:0]   s1_a;
  logic [0:0]   s1_b;
  logic         s1_cin;
  logic         s1_busy;
  logic         s1_done;
  logic [0:0]   s1_sum;
  logic         s1_cout;

  int n_vec = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(W)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s1_start),
    .op_a  (s1_a),
    .op_b  (s1_b),
    .cin   (s1_cin),
    .busy  (s1_busy),
    .done  (s1_done),
    .sum   (s1_sum),
    .cout  (s1_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: plain, 1: extra start pulse during RUN, 2: op_a changes right after acceptance
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int mode, input string tag);
    logic [W:0] exp;
    exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cin = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (mode == 2) op_a = 8'hFF;
    for (int i = 0; i <= W + 2; i++) begin
      @(negedge clk);
      chk($sformatf("%s.done@%0d", tag, i), 32'(done), 32'(i == W));
      chk($sformatf("%s.busy@%0d", tag, i), 32'(busy), 32'(i <= W));
      if (i == W || i == W + 2) begin
        chk($sformatf("%s.sum@%0d", tag, i), 32'(sum), 32'(exp[W-1:0]));
        chk($sformatf("%s.cout@%0d", tag, i), 32'(cout), 32'(exp[W]));
      end
      if (mode == 1 && i == 2) begin
        start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
      end
      if (mode == 1 && i == 3) start = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bb_a [3];
    logic [W-1:0] bb_b [3];
    logic         bb_c [3];
    logic [W:0]   bb_exp;
    logic [1:0]   t1_exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.sum",  32'(sum),  32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h00, 8'h00, 1'b0, 0, "zero");
    do_op(8'hFF, 8'h01, 1'b0, 0, "ripple1");
    do_op(8'hA5, 8'h5A, 1'b1, 0, "ripple2");
    do_op(8'h12, 8'h34, 1'b0, 1, "ignstart");
    do_op(8'h10, 8'h20, 1'b0, 2, "opchange");

    // Reset mid-RUN: outputs clear immediately, no done afterwards
    @(negedge clk);
    start = 1'b1; op_a = 8'h0F; op_b = 8'h01; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.sum",  32'(sum),  32'd0);
    chk("midrst.cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk($sformatf("postrst.done@%0d", i), 32'(done), 32'd0);
      chk($sformatf("postrst.busy@%0d", i), 32'(busy), 32'd0);
    end
    do_op(8'h03, 8'h04, 1'b0, 0, "restart");

    // Back-to-back: start held high, one result every W+2 cycles
    for (int j = 0; j < 3; j++) begin
      bb_a[j] = W'($urandom); bb_b[j] = W'($urandom); bb_c[j] = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b1; op_a = bb_a[0]; op_b = bb_b[0]; cin = bb_c[0];
    @(posedge clk);
    #1;
    op_a = bb_a[1]; op_b = bb_b[1]; cin = bb_c[1];
    for (int i = 0; i < 3 * (W + 2); i++) begin
      @(negedge clk);
      chk($sformatf("b2b.done@%0d", i), 32'(done), 32'((i % (W + 2)) == W));
      if ((i % (W + 2)) == W) begin
        bb_exp = (W+1)'(bb_a[i / (W + 2)]) + (W+1)'(bb_b[i / (W + 2)])
               + (W+1)'(bb_c[i / (W + 2)]);
        chk($sformatf("b2b.sum@%0d", i), 32'({cout, sum}), 32'(bb_exp));
      end
      if (i == W + 2) begin
        op_a = bb_a[2]; op_b = bb_b[2]; cin = bb_c[2];
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized operations
    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rc, int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
    end

    // WIDTH=1 instance: exhaustive truth table
    for (int v = 0; v < 8; v++) begin
      t1_exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk);
      s1_start = 1'b1; s1_a = v[2]; s1_b = v[1]; s1_cin = v[0];
      @(posedge clk);
      #1 s1_start = 1'b0;
      for (int i = 0; i <= 2; i++) begin
        @(negedge clk);
        chk($sformatf("w1.%0d.done@%0d", v, i), 32'(s1_done), 32'(i == 1));
        chk($sformatf("w1.%0d.busy@%0d", v, i), 32'(s1_busy), 32'(i <= 1));
        if (i == 1)
          chk($sformatf("w1.%0d.res", v), 32'({s1_cout, s1_sum}), 32'(t1_exp));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
